draw_scheduler: RTL

Command-driven scheduler that shares the single VGA adapter plot port among the drawing engines (fillscreen, circle, reuleaux). Accepts draw commands into a small FIFO, starts one engine at a time with the start/done handshake, drives the shared shape parameters, and multiplexes the active engine's plot outputs onto VGA_X/VGA_Y/VGA_COLOUR/VGA_PLOT. Sits between the top-level task module (switch/KEY decode) and the engines.

---
 rtl/draw_pkg.sv | 29 ++
 rtl/cmd_fifo.sv | 56 +++++
 rtl/draw_scheduler.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/draw_pkg.sv
// Shared types and constants for the draw command scheduler.
package draw_pkg;

  localparam int unsigned ENG_FILL   = 0;
  localparam int unsigned ENG_CIRCLE = 1;
  localparam int unsigned ENG_REUL   = 2;

  localparam int unsigned ENG_W  = 2;
  localparam int unsigned COL_W  = 3;
  localparam int unsigned X_W    = 8;
  localparam int unsigned Y_W    = 7;
  localparam int unsigned DIAM_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_DROP
  } state_t;

  typedef struct packed {
    logic [ENG_W-1:0]  eng;
    logic [COL_W-1:0]  colour;
    logic [X_W-1:0]    cx;
    logic [Y_W-1:0]    cy;
    logic [DIAM_W-1:0] diam;
  } cmd_t;

endpackage

// File: rtl/cmd_fifo.sv
// Circular command FIFO; DEPTH must be a power of two so pointers wrap naturally.
module cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign full    = (r_count == CW'(DEPTH));
  assign empty   = (r_count == '0);
  assign count   = r_count;
  assign w_push  = push && !full;
  assign w_pop   = pop && !empty;
  assign rd_data = r_mem[r_rd_ptr];

  // Storage array; contents need no reset since count guards reads.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wr_data;
  end

  // Pointers and occupancy; simultaneous push and pop leave count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/draw_scheduler.sv
// Dispatches queued draw commands to one engine at a time and muxes its plot port to the VGA adapter.
module draw_scheduler
  import draw_pkg::*;
#(
  parameter int unsigned N_ENG      = 3,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [ENG_W-1:0]            cmd_eng,
  input  logic [COL_W-1:0]            cmd_colour,
  input  logic [X_W-1:0]              cmd_cx,
  input  logic [Y_W-1:0]              cmd_cy,
  input  logic [DIAM_W-1:0]           cmd_diam,
  output logic [N_ENG-1:0]            eng_start,
  input  logic [N_ENG-1:0]            eng_done,
  input  logic [N_ENG-1:0][X_W-1:0]   eng_x,
  input  logic [N_ENG-1:0][Y_W-1:0]   eng_y,
  input  logic [N_ENG-1:0]            eng_plot,
  output logic [COL_W-1:0]            prm_colour,
  output logic [X_W-1:0]              prm_cx,
  output logic [Y_W-1:0]              prm_cy,
  output logic [DIAM_W-1:0]           prm_diam,
  output logic [X_W-1:0]              vga_x,
  output logic [Y_W-1:0]              vga_y,
  output logic [COL_W-1:0]            vga_colour,
  output logic                        vga_plot,
  output logic                        busy,
  output logic [7:0]                  jobs_done,
  output logic                        bad_cmd
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  cmd_t              w_in;
  cmd_t              w_head;
  logic              w_full;
  logic              w_empty;
  logic              w_pop;
  logic [CNT_W-1:0]  w_count;
  logic              w_head_ok;
  logic [N_ENG-1:0]  w_onehot;

  state_t            r_state;
  logic [ENG_W-1:0]  r_sel;
  logic [N_ENG-1:0]  r_start;
  logic [COL_W-1:0]  r_colour;
  logic [X_W-1:0]    r_cx;
  logic [Y_W-1:0]    r_cy;
  logic [DIAM_W-1:0] r_diam;
  logic [7:0]        r_jobs;
  logic              r_bad;

  assign w_in      = '{eng: cmd_eng, colour: cmd_colour, cx: cmd_cx, cy: cmd_cy, diam: cmd_diam};
  assign cmd_ready = !w_full;
  assign w_pop     = (r_state == ST_LOAD);
  assign w_head_ok = (32'(w_head.eng) < N_ENG);

  cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(cmd_t))
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (cmd_valid),
    .wr_data (w_in),
    .pop     (w_pop),
    .rd_data (w_head),
    .full    (w_full),
    .empty   (w_empty),
    .count   (w_count)
  );

  // Start vector for the engine named by the FIFO head.
  always_comb begin
    w_onehot = '0;
    for (int unsigned i = 0; i < N_ENG; i++) begin
      w_onehot[i] = (32'(w_head.eng) == i);
    end
  end

  // Dispatch FSM: fetch head, hold start until done, wait for done to drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_sel    <= '0;
      r_start  <= '0;
      r_colour <= '0;
      r_cx     <= '0;
      r_cy     <= '0;
      r_diam   <= '0;
      r_jobs   <= '0;
      r_bad    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) r_state <= ST_LOAD;
        end
        ST_LOAD: begin
          r_sel    <= w_head.eng;
          r_colour <= w_head.colour;
          r_cx     <= w_head.cx;
          r_cy     <= w_head.cy;
          r_diam   <= w_head.diam;
          if (w_head_ok) begin
            r_start <= w_onehot;
            r_state <= ST_RUN;
          end else begin
            r_bad   <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          if (eng_done[r_sel]) begin
            r_start <= '0;
            r_jobs  <= r_jobs + 8'd1;
            r_state <= ST_DROP;
          end
        end
        ST_DROP: begin
          if (!eng_done[r_sel]) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Plot mux: only the running engine reaches the adapter.
  always_comb begin
    vga_x      = '0;
    vga_y      = '0;
    vga_colour = '0;
    vga_plot   = 1'b0;
    if (r_state == ST_RUN) begin
      vga_x      = eng_x[r_sel];
      vga_y      = eng_y[r_sel];
      vga_colour = r_colour;
      vga_plot   = eng_plot[r_sel];
    end
  end

  assign eng_start  = r_start;
  assign prm_colour = r_colour;
  assign prm_cx     = r_cx;
  assign prm_cy     = r_cy;
  assign prm_diam   = r_diam;
  assign busy       = (r_state != ST_IDLE) || (w_count != '0);
  assign jobs_done  = r_jobs;
  assign bad_cmd    = r_bad;

endmodule
